// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and architecturally
// named registers used by the decode and jump/link logic.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/reg_write_decoder.sv
// Write-address decoder: turns an enabled register address into one-hot load
// enables. Register 0 is hardwired, so its enable is never raised.
module reg_write_decoder #(
    parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr != '0)) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : reg_write_decoder

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS general-purpose register file: one synchronous write port and
// two combinational read ports, with optional same-cycle write forwarding.
module mips_reg_file #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int unsigned BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0] wr_en;
    logic [DATA_W-1:0]  regs_q [NumRegs];
    logic [DATA_W-1:0]  regs_d [NumRegs];
    logic               wr_live;
    logic               fwd1;
    logic               fwd2;

    // Gating with reset keeps a write from landing when reset wins the edge.
    reg_write_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .en     (we & ~reset),
        .addr   (wa),
        .onehot (wr_en)
    );

    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = wr_en[i] ? wd : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign wr_live = we && !reset && (wa != '0);
    assign fwd1    = (BYPASS != 0) && wr_live && (ra1 == wa);
    assign fwd2    = (BYPASS != 0) && wr_live && (ra2 == wa);

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = fwd1 ? wd : regs_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = fwd2 ? wd : regs_q[ra2];
        end
    end

endmodule : mips_reg_file
